// File: rtl/seqdet_pkg.sv
// Shared constants for the parametrised serial pattern detector: default pattern,
// legal pattern-length range and overlap mode encodings.
package seqdet_pkg;

  localparam int         SEQDET_PAT_W_MIN   = 2;
  localparam int         SEQDET_PAT_W_MAX   = 32;
  localparam logic [2:0] SEQDET_DEFAULT_PAT = 3'b101;

  localparam logic SEQDET_OVERLAP    = 1'b1;
  localparam logic SEQDET_NONOVERLAP = 1'b0;

endpackage

// File: rtl/seqdet_sat_counter.sv
// Saturating up-counter with synchronous clear; the count is visible one cycle after inc.
// No backpressure: increments requested at all-ones are dropped.
module seqdet_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (clr) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/seq_detector_param.sv
// Serial pattern detector: z pulses on the edge sampling the last pattern bit (registered, 1 cycle).
// No backpressure; in_valid gates sampling. Match counter present only with SEQDET_CNT_EN.
module seq_detector_param
  import seqdet_pkg::*;
#(
  parameter int               PAT_W       = 3,
  parameter logic [PAT_W-1:0] DEFAULT_PAT = PAT_W'(SEQDET_DEFAULT_PAT),
  parameter int               CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  input  logic             in_valid,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  output logic             z
`ifdef SEQDET_CNT_EN
  ,
  output logic [CNT_W-1:0] match_cnt
`endif
);

  localparam int                HIST_W   = PAT_W - 1;
  localparam int                FILL_W   = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

  if (PAT_W < SEQDET_PAT_W_MIN || PAT_W > SEQDET_PAT_W_MAX) begin : g_bad_pat_w
    $error("seq_detector_param: PAT_W out of range");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("seq_detector_param: CNT_W must be at least 1");
  end
  if (SEQDET_OVERLAP == SEQDET_NONOVERLAP) begin : g_bad_modes
    $error("seq_detector_param: overlap mode encodings collide");
  end

  logic [PAT_W-1:0]  pat_q, pat_d;
  logic [HIST_W-1:0] hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              z_q, z_d;
  logic [PAT_W-1:0]  cand;
  logic              full;
  logic              hit;

  always_comb begin
    cand   = {hist_q, x};
    full   = (fill_q == FILL_MAX);
    hit    = in_valid && !pat_load && full && (cand == pat_q);
    pat_d  = pat_q;
    hist_d = hist_q;
    fill_d = fill_q;
    z_d    = 1'b0;
    if (pat_load) begin
      // A bit arriving with the load belongs to the old pattern and is dropped.
      pat_d  = pat_in;
      hist_d = '0;
      fill_d = '0;
    end else if (in_valid) begin
      hist_d = cand[HIST_W-1:0];
      if (hit) begin
        z_d    = 1'b1;
        fill_d = (overlap == SEQDET_NONOVERLAP) ? '0 : fill_q;
      end else if (!full) begin
        fill_d = fill_q + FILL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q  <= DEFAULT_PAT;
      hist_q <= '0;
      fill_q <= '0;
      z_q    <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      z_q    <= z_d;
    end
  end

  assign z = z_q;

`ifdef SEQDET_CNT_EN
  seqdet_sat_counter #(.W(CNT_W)) u_cnt (
    .clk (clk),
    .clr (rst),
    .inc (hit),
    .cnt (match_cnt)
  );
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: vector table plus hand-written corner sequences.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst, x, in_valid, overlap, pat_load;
  logic [2:0] pat_in;
  logic       z;
`ifdef SEQDET_CNT_EN
  logic [7:0] match_cnt;
  logic       z_s;
  logic [1:0] match_cnt_s;
`endif

  always #5 clk = ~clk;

  seq_detector_param dut (
    .clk      (clk),
    .rst      (rst),
    .x        (x),
    .in_valid (in_valid),
    .overlap  (overlap),
    .pat_load (pat_load),
    .pat_in   (pat_in),
    .z        (z)
`ifdef SEQDET_CNT_EN
    ,
    .match_cnt(match_cnt)
`endif
  );

`ifdef SEQDET_CNT_EN
  seq_detector_param #(.CNT_W(2)) dut_s (
    .clk      (clk),
    .rst      (rst),
    .x        (x),
    .in_valid (in_valid),
    .overlap  (overlap),
    .pat_load (pat_load),
    .pat_in   (pat_in),
    .z        (z_s),
    .match_cnt(match_cnt_s)
  );
`endif

  typedef struct {
    logic       rst;
    logic       ld;
    logic [2:0] pin;
    logic       vld;
    logic       x;
    logic       ovl;
    logic       ez;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic add(input logic r, input logic ld, input logic [2:0] pin,
                     input logic vld, input logic xb, input logic ovl, input logic ez);
    vec_t v;
    v.rst = r; v.ld = ld; v.pin = pin; v.vld = vld; v.x = xb; v.ovl = ovl; v.ez = ez;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Apply inputs, clock once, then sample just after the edge.
  task automatic step(input logic r, input logic ld, input logic [2:0] pin,
                      input logic vld, input logic xb, input logic ovl);
    rst = r; pat_load = ld; pat_in = pin; in_valid = vld; x = xb; overlap = ovl;
    @(posedge clk);
    #1;
  endtask

  task automatic bit_in(input logic xb, input logic ovl);
    step(1'b0, 1'b0, 3'b000, 1'b1, xb, ovl);
  endtask

  initial begin
    rst = 1'b0; x = 1'b0; in_valid = 1'b0; overlap = 1'b1; pat_load = 1'b0; pat_in = 3'b000;

    // Reset, then default pattern overlapping: 10101 -> hits on bits 3 and 5.
    add(1,0,3'b000,0,0,1,0);
    add(0,0,3'b000,1,1,1,0); add(0,0,3'b000,1,0,1,0); add(0,0,3'b000,1,1,1,1);
    add(0,0,3'b000,1,0,1,0); add(0,0,3'b000,1,1,1,1);
    // Non-overlapping: 10101 -> hit on bit 3 only.
    add(1,0,3'b000,0,0,0,0);
    add(0,0,3'b000,1,1,0,0); add(0,0,3'b000,1,0,0,0); add(0,0,3'b000,1,1,0,1);
    add(0,0,3'b000,1,0,0,0); add(0,0,3'b000,1,1,0,0);
    // Load 110, stream 1110 -> hit on bit 4.
    add(0,1,3'b110,0,0,1,0);
    add(0,0,3'b000,1,1,1,0); add(0,0,3'b000,1,1,1,0); add(0,0,3'b000,1,1,1,0);
    add(0,0,3'b000,1,0,1,1);
    // Load 111 overlapping, stream 11111 -> hits on bits 3,4,5.
    add(0,1,3'b111,0,0,1,0);
    add(0,0,3'b000,1,1,1,0); add(0,0,3'b000,1,1,1,0); add(0,0,3'b000,1,1,1,1);
    add(0,0,3'b000,1,1,1,1); add(0,0,3'b000,1,1,1,1);
    add(0,0,3'b000,0,1,1,0);
    // Back to 101; stream with 2-cycle gaps: 1 _ _ 0 _ _ 1.
    add(0,1,3'b101,0,0,1,0);
    add(0,0,3'b000,1,1,1,0); add(0,0,3'b000,0,0,1,0); add(0,0,3'b000,0,1,1,0);
    add(0,0,3'b000,1,0,1,0); add(0,0,3'b000,0,1,1,0); add(0,0,3'b000,0,0,1,0);
    add(0,0,3'b000,1,1,1,1); add(0,0,3'b000,0,1,1,0);
    // Mode change mid-stream: overlap on for 101, off for the next decision.
    add(0,0,3'b000,1,0,1,0); add(0,0,3'b000,1,1,0,1);
    add(0,0,3'b000,1,0,0,0); add(0,0,3'b000,1,1,0,0);
    // Reset beats a simultaneous load; pattern stays 101.
    add(1,1,3'b111,0,0,1,0);
    add(0,0,3'b000,1,1,1,0); add(0,0,3'b000,1,0,1,0); add(0,0,3'b000,1,1,1,1);
    // Load with a valid bit: that bit is dropped, so 0,1 afterwards cannot match.
    add(0,1,3'b101,1,1,1,0);
    add(0,0,3'b000,1,0,1,0); add(0,0,3'b000,1,1,1,0);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].ld, vecs[i].pin, vecs[i].vld, vecs[i].x, vecs[i].ovl);
      check($sformatf("vec%0d_z", i), int'(z), int'(vecs[i].ez));
    end

    // Reset mid-stream drops partial history; a fresh 101 is needed afterwards.
    step(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
    bit_in(1'b1, 1'b1); bit_in(1'b0, 1'b1);
    step(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
    check("rst_mid_z", int'(z), 0);
    bit_in(1'b1, 1'b1); check("after_rst_b1", int'(z), 0);
    bit_in(1'b0, 1'b1); check("after_rst_b2", int'(z), 0);
    bit_in(1'b1, 1'b1); check("after_rst_b3", int'(z), 1);

`ifdef SEQDET_CNT_EN
    step(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
    check("cnt_reset", int'(match_cnt), 0);
    bit_in(1'b1, 1'b1); bit_in(1'b0, 1'b1); bit_in(1'b1, 1'b1);
    bit_in(1'b0, 1'b1); bit_in(1'b1, 1'b1);
    check("cnt_ovl_10101", int'(match_cnt), 2);
    step(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    bit_in(1'b1, 1'b0); bit_in(1'b0, 1'b0); bit_in(1'b1, 1'b0);
    bit_in(1'b0, 1'b0); bit_in(1'b1, 1'b0);
    check("cnt_novl_10101", int'(match_cnt), 1);
    step(1'b0, 1'b1, 3'b111, 1'b0, 1'b0, 1'b1);
    check("cnt_held_on_load", int'(match_cnt), 1);
    for (int i = 0; i < 5; i++) bit_in(1'b1, 1'b1);
    check("cnt_after_111", int'(match_cnt), 4);
    check("small_z_111", int'(z_s), 1);
    check("small_cnt_sat", int'(match_cnt_s), 3);
    bit_in(1'b1, 1'b1);
    step(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
    check("cnt_after_more", int'(match_cnt), 5);
    check("small_cnt_held", int'(match_cnt_s), 3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
